// File: rtl/sevenseg_scan.sv
// Time-multiplexed BCD 7-segment scanner with per-frame snapshot, leading-zero blanking and DPs.
// Optional blink support is compiled in when the BLINK_EN macro is defined.
module sevenseg_scan #(
    parameter int NDIG         = 4,
    parameter int DIV          = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic [4*NDIG-1:0]   BCD,
    input  logic [NDIG-1:0]     DP,
    input  logic                LZB,
`ifdef BLINK_EN
    input  logic [NDIG-1:0]     BLINK,
`endif
    output logic [7:0]          SEG,
    output logic [NDIG-1:0]     DIG,
    output logic                FRAME
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (NDIG < 1 || NDIG > 8 || DIV < 1 || BLINK_FRAMES < 1) begin : g_bad_param
        $error("sevenseg_scan: parameter out of range");
    end

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] snap_q, snap_d;
    logic              loaded_q, loaded_d;
    logic [7:0]        seg_q, seg_d;
    logic [NDIG-1:0]   dig_q, dig_d;
    logic              frame_q, frame_d;
    logic              tick, last_dig, load;
    logic [NDIG-1:0]   lead_zero;
    logic              run_zero;
    logic [3:0]        cur_bcd;
    logic [7:0]        dec_val;
    logic              blank;

    function automatic logic [7:0] dec(input logic [3:0] n);
        case (n)
            4'd0:    dec = 8'hFC;
            4'd1:    dec = 8'h60;
            4'd2:    dec = 8'hDA;
            4'd3:    dec = 8'hF2;
            4'd4:    dec = 8'h66;
            4'd5:    dec = 8'hB6;
            4'd6:    dec = 8'hBE;
            4'd7:    dec = 8'hE0;
            4'd8:    dec = 8'hFE;
            4'd9:    dec = 8'hF6;
            default: dec = 8'h00;
        endcase
    endfunction

    // Slot timer counts down the remaining cycles of the current digit slot.
    always_comb begin
        tick     = EN && (cnt_q == '0);
        last_dig = (idx_q == IW'(NDIG - 1));
        load     = EN && (!loaded_q || (tick && last_dig));
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        snap_d   = snap_q;
        loaded_d = loaded_q;
        if (EN) begin
            cnt_d = tick ? CW'(DIV - 1) : cnt_q - 1'b1;
        end
        if (tick) begin
            idx_d = last_dig ? '0 : idx_q + 1'b1;
        end
        if (load) begin
            snap_d   = BCD;
            loaded_d = 1'b1;
        end
        frame_d = load;
    end

    // lead_zero[i] is set when snapshot digits NDIG-1 down to i are all zero.
    always_comb begin
        lead_zero = '0;
        run_zero  = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            run_zero     = run_zero && (snap_q[4*i +: 4] == 4'd0);
            lead_zero[i] = run_zero;
        end
    end

`ifdef BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (load) begin
            if (bcnt_q == '0) begin
                bcnt_d  = BW'(BLINK_FRAMES - 1);
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bcnt_q  <= BW'(BLINK_FRAMES - 1);
            phase_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end
`endif

    always_comb begin
        cur_bcd = snap_q[4*idx_q +: 4];
        dec_val = dec(cur_bcd);
        blank   = LZB && (idx_q != '0) && lead_zero[idx_q];
        seg_d   = 8'h00;
        dig_d   = '0;
        if (EN) begin
            dig_d[idx_q] = 1'b1;
            seg_d        = {(blank ? 7'b0 : dec_val[7:1]), DP[idx_q]};
`ifdef BLINK_EN
            if (phase_q && BLINK[idx_q]) begin
                seg_d = 8'h00;
            end
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q    <= CW'(DIV - 1);
            idx_q    <= '0;
            snap_q   <= '0;
            loaded_q <= 1'b0;
            seg_q    <= 8'h00;
            dig_q    <= '0;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            snap_q   <= snap_d;
            loaded_q <= loaded_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
            frame_q  <= frame_d;
        end
    end

    assign SEG   = seg_q;
    assign DIG   = dig_q;
    assign FRAME = frame_q;

endmodule
